// File: rtl/transfer_merge_if.sv
// Egress bus of the transfer merge stage: the four per-class source FIFO
// read ports plus the single downstream FIFO push port.
// The merge block connects through the master modport; the FIFO side
// (or a bench model of it) connects through the slave modport.
interface transfer_merge_if #(
    parameter int DATA_W = 12
);
    logic              emptyP0;
    logic              emptyP1;
    logic              emptyP2;
    logic              emptyP3;
    logic [DATA_W-1:0] dataInP0;
    logic [DATA_W-1:0] dataInP1;
    logic [DATA_W-1:0] dataInP2;
    logic [DATA_W-1:0] dataInP3;
    logic              popP0;
    logic              popP1;
    logic              popP2;
    logic              popP3;
    logic              almostFullOut;
    logic              pushOut;
    logic [DATA_W-1:0] dataOut;

    modport master (
        input  emptyP0, emptyP1, emptyP2, emptyP3,
        input  dataInP0, dataInP1, dataInP2, dataInP3,
        input  almostFullOut,
        output popP0, popP1, popP2, popP3,
        output pushOut, dataOut
    );

    modport slave (
        output emptyP0, emptyP1, emptyP2, emptyP3,
        output dataInP0, dataInP1, dataInP2, dataInP3,
        output almostFullOut,
        input  popP0, popP1, popP2, popP3,
        input  pushOut, dataOut
    );
endinterface

// File: rtl/transfer_merge.sv
// transfer_merge: drains four per-class source FIFOs onto one downstream
// FIFO. Round-robin arbitration with almost-full backpressure, 2-cycle
// pop-to-push pipeline, and per-port forwarded-word counters readable
// through a req/idx handshake.
// Build option: define MERGE_STRICT_PRIO_EN for fixed priority P0>P1>P2>P3
// (the round-robin pointer then stays at 0).
module transfer_merge #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    transfer_merge_if.master     bus,
    input  logic                 req,
    input  logic [2:0]           idx,
    output logic                 counterValid,
    output logic [CNT_W-1:0]     counterOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        rr_ptr;
    logic [3:0]        empty_v;
    logic [3:0]        pop_v;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [1:0]        scan_idx;
    logic [CNT_W-1:0]  count [4];
    logic              stage_valid;
    logic [1:0]        stage_sel;
    logic [DATA_W-1:0] stage_data;

    assign empty_v   = {bus.emptyP3, bus.emptyP2, bus.emptyP1, bus.emptyP0};
    assign bus.popP0 = pop_v[0];
    assign bus.popP1 = pop_v[1];
    assign bus.popP2 = pop_v[2];
    assign bus.popP3 = pop_v[3];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and grant: first non-empty port scanning from rr_ptr
    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        scan_idx    = 2'd0;
        pop_v       = '0;
        case (state_q)
            IDLE:    if (init) state_d = INIT;
            INIT:    state_d = ACTIVE;
            ACTIVE:  if (init) state_d = INIT;
            default: state_d = IDLE;
        endcase
        if (state_q == ACTIVE && !bus.almostFullOut) begin
            for (int unsigned k = 0; k < 4; k++) begin
                scan_idx = rr_ptr + 2'(k);
                if (!grant_valid && !empty_v[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
        if (grant_valid) pop_v[grant_idx] = 1'b1;
    end

    // Arbitration pointer and per-port forwarded-word counters
    always_ff @(posedge clk) begin
        if (reset || state_q == INIT) begin
            rr_ptr <= '0;
            for (int unsigned i = 0; i < 4; i++) count[i] <= '0;
        end else if (grant_valid) begin
            count[grant_idx] <= count[grant_idx] + CNT_W'(1);
`ifdef MERGE_STRICT_PRIO_EN
            rr_ptr <= '0;
`else
            rr_ptr <= grant_idx + 2'd1;
`endif
        end
    end

    // Source read data for the port popped last cycle
    always_comb begin
        case (stage_sel)
            2'd0:    stage_data = bus.dataInP0;
            2'd1:    stage_data = bus.dataInP1;
            2'd2:    stage_data = bus.dataInP2;
            default: stage_data = bus.dataInP3;
        endcase
    end

    // Pop-to-push pipeline; init does not flush it, reset does
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_sel   <= 2'd0;
            bus.pushOut <= 1'b0;
            bus.dataOut <= '0;
        end else begin
            stage_valid <= grant_valid;
            stage_sel   <= grant_idx;
            bus.pushOut <= stage_valid;
            if (stage_valid) bus.dataOut <= stage_data;
        end
    end

    // Counter read: value as of the request edge, one-cycle strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            counterValid <= 1'b0;
            counterOut   <= '0;
        end else if (req && idx < 3'd4) begin
            counterValid <= 1'b1;
            counterOut   <= count[idx[1:0]];
        end else begin
            counterValid <= 1'b0;
            counterOut   <= '0;
        end
    end

endmodule

// File: tb/tb_transfer_merge.sv
// Bench for transfer_merge: behavioural source FIFOs feed the DUT, the
// stimulus pushes hand-computed expected words/counter values into queues,
// and a monitor on the falling edge pops and compares them.
module tb_transfer_merge;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             init;
    logic             req;
    logic [2:0]       idx;
    logic             counterValid;
    logic [CNT_W-1:0] counterOut;
    logic             af;

    logic [3:0]        src_empty;
    logic [DATA_W-1:0] src_data [4];
    logic [DATA_W-1:0] src_q [4][$];
    logic [3:0]        pop_v;
    logic [3:0]        pend;

    logic [DATA_W-1:0] exp_q [$];
    logic [CNT_W-1:0]  cnt_q [$];
    int unsigned       pop_cyc [$];
    int unsigned       cyc = 0;
    int unsigned       n_total = 0;
    int unsigned       n_pass  = 0;

    transfer_merge_if #(.DATA_W(DATA_W)) bus ();

    transfer_merge #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .bus          (bus),
        .req          (req),
        .idx          (idx),
        .counterValid (counterValid),
        .counterOut   (counterOut)
    );

    assign bus.emptyP0       = src_empty[0];
    assign bus.emptyP1       = src_empty[1];
    assign bus.emptyP2       = src_empty[2];
    assign bus.emptyP3       = src_empty[3];
    assign bus.dataInP0      = src_data[0];
    assign bus.dataInP1      = src_data[1];
    assign bus.dataInP2      = src_data[2];
    assign bus.dataInP3      = src_data[3];
    assign bus.almostFullOut = af;
    assign pop_v = {bus.popP3, bus.popP2, bus.popP1, bus.popP0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Source FIFO model: pops seen in a cycle deliver data the next cycle
    initial begin
        src_empty = '1;
        for (int i = 0; i < 4; i++) src_data[i] = '0;
        forever begin
            @(negedge clk);
            pend = pop_v;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && src_q[i].size() > 0) src_data[i] = src_q[i].pop_front();
                src_empty[i] = (src_q[i].size() == 0);
            end
        end
    end

    // Monitor: legality of pops, push data/latency, counter reads
    initial begin
        forever begin
            @(negedge clk);
            if (pop_v != 4'b0) begin
                chk("pop_legal", (($countones(pop_v) == 1) && ((pop_v & src_empty) == 4'b0) && !af) ? 1 : 0, 1);
                pop_cyc.push_back(cyc);
            end
            if (bus.pushOut) begin
                if (exp_q.size() == 0) chk("unexpected_push", bus.dataOut, -1);
                else chk("push_data", bus.dataOut, exp_q.pop_front());
                if (pop_cyc.size() > 0) chk("push_latency", cyc - pop_cyc.pop_front(), 2);
            end
            if (counterValid) begin
                if (cnt_q.size() == 0) chk("unexpected_counter", counterOut, -1);
                else chk("counter_value", counterOut, cnt_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("init_no_pop", pop_v, 0);
        tick();
    endtask

    task automatic load(input int p, input logic [DATA_W-1:0] w, input bit expect_push);
        src_q[p].push_back(w);
        if (expect_push) exp_q.push_back(w);
    endtask

    task automatic read_cnt(input logic [2:0] i, input logic [CNT_W-1:0] v);
        req = 1'b1;
        idx = i;
        if (i < 3'd4) cnt_q.push_back(v);
        tick();
        req = 1'b0;
        idx = 3'd0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        init  = 1'b0;
        req   = 1'b0;
        idx   = 3'd0;
        af    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pushOut", bus.pushOut, 0);
        chk("rst_dataOut", bus.dataOut, 0);
        chk("rst_counterValid", counterValid, 0);
        chk("rst_counterOut", counterOut, 0);

        // P0 alone: three back-to-back pops, no pops while IDLE
        load(0, 12'd15, 1);
        load(0, 12'd20, 1);
        load(0, 12'd25, 1);
        tick();
        tick();
        chk("idle_no_pop", pop_v, 0);
        do_init();
        chk("p0_pop_c1", pop_v, 4'b0001);
        tick();
        chk("p0_pop_c2", pop_v, 4'b0001);
        tick();
        chk("p0_pop_c3", pop_v, 4'b0001);
        tick();
        chk("p0_pop_c4", pop_v, 0);
        drain(20);
        read_cnt(3'd0, 5'd3);
        tick();

        // All four ports, two words each
        do_init();
`ifdef MERGE_STRICT_PRIO_EN
        load(0, 12'd15, 1);  load(0, 12'd35, 1);
        load(1, 12'h5FF, 1); load(1, 12'd20, 1);
        load(2, 12'hAFF, 1); load(2, 12'd25, 1);
        load(3, 12'hFFF, 1); load(3, 12'd30, 1);
`else
        load(0, 12'd15, 1);  load(1, 12'h5FF, 1);
        load(2, 12'hAFF, 1); load(3, 12'hFFF, 1);
        load(0, 12'd35, 0);  load(1, 12'd20, 0);
        load(2, 12'd25, 0);  load(3, 12'd30, 0);
        exp_q.push_back(12'd35); exp_q.push_back(12'd20);
        exp_q.push_back(12'd25); exp_q.push_back(12'd30);
`endif
        drain(30);
        read_cnt(3'd1, 5'd2);
        read_cnt(3'd3, 5'd2);
        tick();

        // Backpressure: almost-full for 4 cycles mid-stream
        do_init();
        for (int i = 1; i <= 8; i++) load(1, 12'h100 + 12'(i), 1);
        tick();
        tick();
        af = 1'b1;
        tick();
        tick();
        chk("af_no_push_3", bus.pushOut, 0);
        tick();
        chk("af_no_push_4", bus.pushOut, 0);
        tick();
        af = 1'b0;
        drain(30);
        read_cnt(3'd1, 5'd8);
        tick();

        // Counter wrap on P2, out-of-range index
        do_init();
        for (int i = 0; i < 33; i++) load(2, 12'h800 + 12'(i), 1);
        drain(60);
        read_cnt(3'd2, 5'd1);
        read_cnt(3'd5, 5'd0);
        chk("idx5_valid", counterValid, 0);
        chk("idx5_out", counterOut, 0);
        tick();

        // Reset with two words in flight: both dropped
        for (int i = 1; i <= 4; i++) load(3, 12'hC00 + 12'(i), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_flush", bus.pushOut, 0);
        src_q[3].delete();
        pop_cyc.delete();
        tick();
        chk("reset_flush_2", bus.pushOut, 0);
        do_init();
        for (int i = 0; i < 4; i++) read_cnt(3'(i), 5'd0);
        tick();
        tick();

        chk("exp_q_empty", exp_q.size(), 0);
        chk("cnt_q_empty", cnt_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
